// File: rtl/sdram_init_ctrl_if.sv
// Command/address bus from the SDRAM power-up sequencer to the controller mux.
// SDRAM_INIT_STATE_OUT_EN adds the init_state debug signal.
interface sdram_init_ctrl_if;
  logic [3:0]  init_cmd;
  logic [1:0]  init_ba;
  logic [12:0] init_addr;
  logic        init_end;
`ifdef SDRAM_INIT_STATE_OUT_EN
  logic [2:0]  init_state;

  modport master (output init_cmd, output init_ba, output init_addr, output init_end,
                  output init_state);
  modport slave  (input init_cmd, input init_ba, input init_addr, input init_end,
                  input init_state);
`else
  modport master (output init_cmd, output init_ba, output init_addr, output init_end);
  modport slave  (input init_cmd, input init_ba, input init_addr, input init_end);
`endif
endinterface

// File: rtl/sdram_init_ctrl.sv
// SDR SDRAM power-up sequencer: wait, PRECHARGE ALL, AREF_NUM x AUTO REFRESH, LOAD MODE.
// Optional macro SDRAM_INIT_STATE_OUT_EN exports the FSM state on init_state.
module sdram_init_ctrl #(
  parameter int          T_POWER  = 20000,
  parameter int          TRP_CLK  = 2,
  parameter int          TRFC_CLK = 7,
  parameter int          TMRD_CLK = 3,
  parameter int          AREF_NUM = 8,
  parameter logic [12:0] MODE_VAL = 13'b000_0_00_011_0_111
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  sdram_init_ctrl_if.master   init_bus
);

  localparam int PWR_W    = $clog2(T_POWER + 1);
  localparam int AREF_W   = $clog2(AREF_NUM + 1);
  localparam int WAIT_MX1 = (TRP_CLK > TRFC_CLK) ? TRP_CLK : TRFC_CLK;
  localparam int WAIT_MX2 = (WAIT_MX1 > TMRD_CLK) ? WAIT_MX1 : TMRD_CLK;
  localparam int WAIT_MAX = (WAIT_MX2 > 1) ? WAIT_MX2 : 1;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [PWR_W-1:0]  PWR_LAST  = PWR_W'(T_POWER - 1);
  localparam logic [WAIT_W-1:0] TRP_LAST  = WAIT_W'(TRP_CLK - 1);
  localparam logic [WAIT_W-1:0] TRFC_LAST = WAIT_W'(TRFC_CLK - 1);
  localparam logic [WAIT_W-1:0] TMRD_LAST = WAIT_W'(TMRD_CLK - 1);
  localparam logic [AREF_W-1:0] AREF_TOT  = AREF_W'(AREF_NUM);

  localparam logic [3:0]  CMD_NOP  = 4'b0111;
  localparam logic [3:0]  CMD_PRE  = 4'b0010;
  localparam logic [3:0]  CMD_AREF = 4'b0001;
  localparam logic [3:0]  CMD_LMR  = 4'b0000;
  localparam logic [1:0]  BA_DEF   = 2'b11;
  localparam logic [12:0] ADDR_DEF = 13'h1FFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    TRP  = 3'd2,
    AR   = 3'd3,
    TRFC = 3'd4,
    MRS  = 3'd5,
    TMRD = 3'd6,
    END  = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [PWR_W-1:0]    pwr_cnt_q, pwr_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [AREF_W-1:0]   aref_cnt_q, aref_cnt_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [1:0]          ba_q, ba_d;
  logic [12:0]         addr_q, addr_d;
  logic                end_q, end_d;

  // Next-state and counters; each wait state lasts exactly its *_CLK cycles.
  always_comb begin
    state_d    = state_q;
    pwr_cnt_d  = pwr_cnt_q;
    wait_cnt_d = wait_cnt_q;
    aref_cnt_d = aref_cnt_q;
    case (state_q)
      IDLE: begin
        if (pwr_cnt_q == PWR_LAST) begin
          state_d = PRE;
        end else begin
          pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
        end
      end
      PRE: begin
        state_d    = TRP;
        wait_cnt_d = '0;
      end
      TRP: begin
        if (wait_cnt_q == TRP_LAST) begin
          state_d    = AR;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      AR: begin
        state_d    = TRFC;
        wait_cnt_d = '0;
        aref_cnt_d = aref_cnt_q + AREF_W'(1);
      end
      TRFC: begin
        if (wait_cnt_q == TRFC_LAST) begin
          wait_cnt_d = '0;
          if (aref_cnt_q < AREF_TOT) begin
            state_d = AR;
          end else begin
            state_d = MRS;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      MRS: begin
        state_d    = TMRD;
        wait_cnt_d = '0;
      end
      TMRD: begin
        if (wait_cnt_q == TMRD_LAST) begin
          state_d    = END;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      END: begin
        state_d = END;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode the next state so the command lands in the same cycle the state is entered.
  always_comb begin
    cmd_d  = CMD_NOP;
    ba_d   = BA_DEF;
    addr_d = ADDR_DEF;
    end_d  = 1'b0;
    case (state_d)
      PRE: begin
        cmd_d = CMD_PRE;
      end
      AR: begin
        cmd_d = CMD_AREF;
      end
      MRS: begin
        cmd_d  = CMD_LMR;
        ba_d   = 2'b00;
        addr_d = MODE_VAL;
      end
      END: begin
        end_d = 1'b1;
      end
      default: begin
        cmd_d = CMD_NOP;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      pwr_cnt_q  <= '0;
      wait_cnt_q <= '0;
      aref_cnt_q <= '0;
      cmd_q      <= CMD_NOP;
      ba_q       <= BA_DEF;
      addr_q     <= ADDR_DEF;
      end_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwr_cnt_q  <= pwr_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      aref_cnt_q <= aref_cnt_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
      end_q      <= end_d;
    end
  end

  assign init_bus.init_cmd  = cmd_q;
  assign init_bus.init_ba   = ba_q;
  assign init_bus.init_addr = addr_q;
  assign init_bus.init_end  = end_q;
`ifdef SDRAM_INIT_STATE_OUT_EN
  assign init_bus.init_state = state_q;
`endif

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Directed bench for sdram_init_ctrl: short power-up wait instance plus a default-parameter instance.
module tb_sdram_init_ctrl;

  localparam int TP = 100;

  logic sys_clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_init_ctrl_if bus_a ();
  sdram_init_ctrl_if bus_b ();

  sdram_init_ctrl #(.T_POWER(TP)) dut_a (
    .sys_clk  (sys_clk),
    .sys_rst  (rst_a),
    .init_bus (bus_a)
  );

  sdram_init_ctrl dut_b (
    .sys_clk  (sys_clk),
    .sys_rst  (rst_b),
    .init_bus (bus_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Hand-derived schedule for T_POWER=100: PRE 100, AREF 103+8k, MRS 167, done 171.
  function automatic logic [3:0] exp_cmd(input int n);
    if (n == TP) return 4'b0010;
    if (n >= TP + 3 && n <= TP + 59 && ((n - TP - 3) % 8) == 0) return 4'b0001;
    if (n == TP + 67) return 4'b0000;
    return 4'b0111;
  endfunction

  function automatic logic [2:0] exp_state(input int n);
    if (n < TP) return 3'd0;
    if (n == TP) return 3'd1;
    if (n < TP + 3) return 3'd2;
    if (n < TP + 67) return (((n - TP - 3) % 8) == 0) ? 3'd3 : 3'd4;
    if (n == TP + 67) return 3'd5;
    if (n < TP + 71) return 3'd6;
    return 3'd7;
  endfunction

  task automatic check_reset_a(input string tag);
    check_eq({tag, " cmd"},  bus_a.init_cmd,  4'b0111);
    check_eq({tag, " ba"},   bus_a.init_ba,   2'b11);
    check_eq({tag, " addr"}, bus_a.init_addr, 13'h1FFF);
    check_eq({tag, " end"},  bus_a.init_end,  1'b0);
`ifdef SDRAM_INIT_STATE_OUT_EN
    check_eq({tag, " state"}, bus_a.init_state, 3'd0);
`endif
  endtask

  task automatic run_seq(input int ncyc, input string ph);
    int ar_cnt;
    ar_cnt = 0;
    for (int n = 1; n <= ncyc; n++) begin
      step();
      if (bus_a.init_cmd == 4'b0001) ar_cnt++;
      check_eq($sformatf("%s cmd@%0d", ph, n), bus_a.init_cmd, exp_cmd(n));
      check_eq($sformatf("%s ba@%0d", ph, n), bus_a.init_ba,
               (n == TP + 67) ? 2'b00 : 2'b11);
      check_eq($sformatf("%s addr@%0d", ph, n), bus_a.init_addr,
               (n == TP + 67) ? 13'h0037 : 13'h1FFF);
      check_eq($sformatf("%s end@%0d", ph, n), bus_a.init_end, (n >= TP + 71) ? 1'b1 : 1'b0);
`ifdef SDRAM_INIT_STATE_OUT_EN
      check_eq($sformatf("%s state@%0d", ph, n), bus_a.init_state, exp_state(n));
`endif
    end
    if (ncyc >= TP + 60) check_eq({ph, " aref_count"}, ar_cnt, 8);
  endtask

  initial begin
    int pre_cyc;
    int mrs_cyc;
    int end_cyc;
    int ar_b;
    rst_a = 1'b1;
    rst_b = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step();
      check_reset_a($sformatf("hold%0d", i));
    end
    check_eq("b_reset cmd", bus_b.init_cmd, 4'b0111);

    rst_a = 1'b0;
    run_seq(200, "run1");

    for (int i = 0; i < 1000; i++) begin
      step();
      check_eq($sformatf("sticky end+%0d", i), bus_a.init_end, 1'b1);
      check_eq($sformatf("sticky cmd+%0d", i), bus_a.init_cmd, 4'b0111);
    end

    rst_a = 1'b1;
    step();
    check_reset_a("clr0");
    step();
    check_reset_a("clr1");
    rst_a = 1'b0;

    run_seq(129, "pre_rst");
    rst_a = 1'b1;
    step();
    check_reset_a("mid130");
    step();
    check_reset_a("mid131");
    rst_a = 1'b0;
    run_seq(200, "restart");

    pre_cyc = 0;
    mrs_cyc = 0;
    end_cyc = 0;
    ar_b    = 0;
    rst_b   = 1'b0;
    for (int n = 1; n <= 20100; n++) begin
      step();
      if (bus_b.init_cmd == 4'b0010 && pre_cyc == 0) pre_cyc = n;
      if (bus_b.init_cmd == 4'b0001) ar_b++;
      if (bus_b.init_cmd == 4'b0000 && mrs_cyc == 0) begin
        mrs_cyc = n;
        check_eq("dflt mrs ba", bus_b.init_ba, 2'b00);
        check_eq("dflt mrs addr", bus_b.init_addr, 13'h0037);
      end
      if (bus_b.init_end == 1'b1 && end_cyc == 0) end_cyc = n;
    end
    check_eq("dflt pre_cycle", pre_cyc, 20000);
    check_eq("dflt aref_count", ar_b, 8);
    check_eq("dflt mrs_cycle", mrs_cyc, 20067);
    check_eq("dflt end_cycle", end_cyc, 20071);
    check_eq("dflt end_final", bus_b.init_end, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_init_ctrl.md
Name: sdram_init_ctrl

Overview:
- Power-up initialization sequencer for a 16-bit, 4-bank SDR SDRAM (13-bit row address, 9-bit column address) clocked at 100 MHz.
- Sequence: wait 200 us, PRECHARGE ALL, 8× AUTO REFRESH, LOAD MODE REGISTER, then assert init_end.
- Drives {CS_n,RAS_n,CAS_n,WE_n}, bank and address; the top-level SDRAM controller muxes these until init_end rises.

Parameters:
- T_POWER, 20000, power-up wait in clocks (200 us at 100 MHz).
- TRP_CLK, 2, NOP cycles after PRECHARGE.
- TRFC_CLK, 7, NOP cycles after each AUTO REFRESH.
- TMRD_CLK, 3, NOP cycles after LOAD MODE REGISTER.
- AREF_NUM, 8, number of AUTO REFRESH commands.
- MODE_VAL, 13'b000_0_00_011_0_111, mode register value: burst write, CAS latency 3, sequential burst, full-page burst.

Ports:
- sys_clk  input  1  100 MHz clock; all logic on the rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- init_cmd  output  4  {CS_n,RAS_n,CAS_n,WE_n}.
- init_ba  output  2  bank address.
- init_addr  output  13  address bus A12..A0.
- init_end  output  1  initialization complete; sticky high.

Behaviour:
- All outputs are registered.
- Reset values: init_cmd=4'b0111 (NOP), init_ba=2'b11, init_addr=13'h1FFF, init_end=0.
- Command encodings: NOP 0111, PRECHARGE 0010, AUTO REFRESH 0001, LOAD MODE 0000.
- States: IDLE → PRE → TRP → AR → TRFC → MRS → TMRD → END.
- Cycle numbering: cycle n is the n-th rising edge with sys_rst=0.
- IDLE: a power counter increments each cycle. The PRECHARGE command appears on the outputs after cycle T_POWER.
- PRE: one-cycle command; init_ba=2'b11, init_addr=13'h1FFF (A10=1 selects all banks).
- TRP: exactly TRP_CLK NOP cycles.
- AR: one-cycle AUTO REFRESH; init_ba/init_addr at default values. The refresh counter increments.
- TRFC: exactly TRFC_CLK NOP cycles. Then return to AR if fewer than AREF_NUM refreshes have been issued; otherwise go to MRS.
- MRS: one-cycle LOAD MODE; init_ba=2'b00, init_addr=MODE_VAL.
- TMRD: exactly TMRD_CLK NOP cycles.
- END: NOP, defaults on ba/addr, init_end=1. Held until reset; no further commands.
- Command spacing:
  - PRECHARGE at cycle P.
  - AR_k at P+(TRP_CLK+1)+(k-1)(TRFC_CLK+1).
  - MRS at AR_AREF_NUM+TRFC_CLK+1.
  - init_end at MRS+TMRD_CLK+1.
- Every non-command cycle is NOP with default ba/addr.
- Reset mid-sequence (any state, including END):
  - outputs return to reset values on the next edge;
  - all counters clear;
  - the full sequence restarts, including the full T_POWER wait.
- Counter widths must hold T_POWER (15 bits at default) and AREF_NUM without wrap. Counters saturate or stop in END; no wrap-around re-triggers the sequence.

Optional Feature:
- Macro SDRAM_INIT_STATE_OUT_EN.
- Defined: adds output port init_state (3-bit) carrying the current state encoding: IDLE=0, PRE=1, TRP=2, AR=3, TRFC=4, MRS=5, TMRD=6, END=7. It resets to 0.
- Undefined: the port does not exist; behaviour is otherwise identical.

Test Plan:
- Reset hold: sys_rst=1 for 5 cycles → init_cmd=0111, init_ba=11, init_addr=1FFF, init_end=0 throughout.
- Timing (T_POWER=100, others default): release reset → PRECHARGE at cycle 100 with addr[10]=1; AUTO REFRESH at cycles 103,111,119,127,135,143,151,159 (exactly 8); MRS at 167 with ba=00 and addr=13'h0037; init_end=1 from cycle 171 onward; all other cycles NOP.
- Default parameters: PRECHARGE at cycle 20000; init_end at 20071; an attached SDRAM model reports no timing violations.
- Mid-sequence reset (T_POWER=100): assert sys_rst at cycle 130 for 2 cycles → outputs return to NOP/defaults; after release, PRECHARGE occurs 100 cycles later and 8 new refreshes follow.
- Sticky done: run 1000 cycles after init_end → init_end stays 1 and init_cmd stays 0111; a reset clears init_end.
- With SDRAM_INIT_STATE_OUT_EN: init_state steps 0→1→2→3→4…→5→6→7, matching the command timing above.
